// File: rtl/pdp11_exec_pkg.sv
// Shared definitions for the pdp11_exec register-mode execute sequencer.
//   - Sequencer state encoding and instruction-class codes.
//   - classify(): maps a 16-bit instruction word to its class.
//   - decode(): derives the register-file selects and write-back controls.
// Optional feature macro: PDP11_EIS_EN. When it is defined, ASH (072RSS) and
// XOR (074RSS) are decoded in register mode. When it is undefined, both
// encodings classify as ILLEGAL.
package pdp11_exec_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_TRAP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CLS_DOUBLE  = 2'd0,
        CLS_SINGLE  = 2'd1,
        CLS_EIS     = 2'd2,
        CLS_ILLEGAL = 2'd3
    } cls_e;

    typedef struct packed {
        logic [2:0] ra;      // register presented on alu a
        logic [2:0] rb;      // register presented on alu b
        logic       a_zero;  // single-operand ops present a=0
        logic       wr_en;   // result written back to a register
        logic [2:0] wa;      // write-back register
        logic       sxt;     // MOVB: sign-extend byte result into [15:8]
        logic       mtps;    // MTPS: T bit of the PSW is preserved
    } dec_t;

    function automatic cls_e classify(input logic [15:0] ir);
        cls_e c;
        logic single_ok;
        c = CLS_ILLEGAL;
        single_ok = ((ir[11:6] >= 6'o50) && (ir[11:6] <= 6'o63)) ||
                    (ir[15:6] == 10'o0003) || (ir[15:6] == 10'o0067) ||
                    (ir[15:6] == 10'o1064) || (ir[15:6] == 10'o1067);
        if ((ir[14:12] != 3'o0) && (ir[14:12] != 3'o7)) begin
            if ((ir[11:9] == 3'o0) && (ir[5:3] == 3'o0))
                c = CLS_DOUBLE;
        end else if (ir[14:12] == 3'o0) begin
            if (single_ok && (ir[5:3] == 3'o0))
                c = CLS_SINGLE;
        end
`ifdef PDP11_EIS_EN
        if (((ir[15:9] == 7'o072) || (ir[15:9] == 7'o074)) && (ir[5:3] == 3'o0))
            c = CLS_EIS;
`endif
        return c;
    endfunction

    function automatic dec_t decode(input logic [15:0] ir);
        dec_t d;
        cls_e c;
        c        = classify(ir);
        d.ra     = ir[8:6];
        d.rb     = ir[2:0];
        d.wa     = ir[2:0];
        d.a_zero = (c == CLS_SINGLE);
        d.sxt    = (c == CLS_DOUBLE) && ir[15] && (ir[14:12] == 3'o1);
        d.mtps   = (c == CLS_SINGLE) && (ir[15:6] == 10'o1064);
        d.wr_en  = 1'b0;
        case (c)
            // CMP(B) and BIT(B) only set condition codes
            CLS_DOUBLE: d.wr_en = (ir[14:12] != 3'o2) && (ir[14:12] != 3'o3);
            // TST(B) and MTPS only set the PSW
            CLS_SINGLE: d.wr_en = (ir[11:6] != 6'o57) && !d.mtps;
`ifdef PDP11_EIS_EN
            CLS_EIS: begin
                d.wr_en = 1'b1;
                // ASH: count register in the low field, shifted register in R
                if (ir[11:9] == 3'o2) begin
                    d.ra = ir[2:0];
                    d.rb = ir[8:6];
                    d.wa = ir[8:6];
                end
            end
`endif
            default: d.wr_en = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pdp11_exec_regfile.sv
// pdp11_regfile: 8 x 16-bit general register file (R0-R7).
// Ports:
//   clk, reset      clock, asynchronous active-high reset (all regs <= REG_RESET)
//   ra_i/ra_o       async read port A
//   rb_i/rb_o       async read port B
//   dbg_i/dbg_o     async debug read port
//   we_i/wa_i/wd_i  synchronous write port
module pdp11_regfile #(
    parameter logic [15:0] REG_RESET = 16'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ra_i,
    input  logic [2:0]  rb_i,
    input  logic [2:0]  dbg_i,
    input  logic        we_i,
    input  logic [2:0]  wa_i,
    input  logic [15:0] wd_i,
    output logic [15:0] ra_o,
    output logic [15:0] rb_o,
    output logic [15:0] dbg_o
);

    logic [15:0] r_q [8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_q[i] <= REG_RESET;
        end else if (we_i) begin
            r_q[wa_i] <= wd_i;
        end
    end

    assign ra_o  = r_q[ra_i];
    assign rb_o  = r_q[rb_i];
    assign dbg_o = r_q[dbg_i];

endmodule

// File: rtl/pdp11_exec.sv
// pdp11_exec: register-mode PDP-11 execute sequencer driving an external alu.
// Accepts one instruction per valid/ready handshake, presents operands and
// the PSW to the alu, captures the alu result and writes back register + PSW.
// Unsupported encodings (including any non-register mode) pulse trap.
// Ports:
//   clk, reset                clock, asynchronous active-high reset
//   instr_valid/instr/instr_ready   instruction handshake
//   done, trap                one-cycle retire / unsupported pulses
//   alu_op/alu_a/alu_b/alu_ps to alu;  alu_d/alu_psr from alu
//   psw                       current processor status word
//   dbg_sel/dbg_data          combinational debug register read
// Optional feature macro: PDP11_EIS_EN (ASH/XOR decode, see pdp11_exec_pkg).
module pdp11_exec
    import pdp11_exec_pkg::*;
#(
    parameter logic [7:0]  RESET_PSW = 8'h00,
    parameter logic [15:0] REG_RESET = 16'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        done,
    output logic        trap,
    output logic [9:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_ps,
    input  logic [15:0] alu_d,
    input  logic [7:0]  alu_psr,
    output logic [7:0]  psw,
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg_data
);

    state_e      state_q;
    logic [15:0] ir_q;
    logic [7:0]  psw_q;
    logic [7:0]  psw_d;
    logic        done_q;
    logic        trap_q;
    logic [15:0] d_q;
    logic [7:0]  psr_q;
    logic [15:0] wd_d;
    logic [15:0] rd_a;
    logic [15:0] rd_b;
    logic        we;
    cls_e        cls_in;
    dec_t        dec_ir;

    always_comb begin
        cls_in = classify(instr);
        dec_ir = decode(ir_q);
    end

    // MOVB to a register sign-extends; other byte ops rely on the alu
    // having preserved the high byte.
    assign wd_d  = dec_ir.sxt ? {{8{d_q[7]}}, d_q[7:0]} : d_q;
    assign psw_d = dec_ir.mtps ? {psr_q[7:5], psw_q[4], psr_q[3:0]} : psr_q;
    assign we    = (state_q == S_WB) && dec_ir.wr_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= 16'h0;
            psw_q   <= RESET_PSW;
            done_q  <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            trap_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir_q <= instr;
                        if (cls_in == CLS_ILLEGAL) begin
                            state_q <= S_TRAP;
                            trap_q  <= 1'b1;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    state_q <= S_WB;
                    done_q  <= 1'b1;
                end
                S_WB: begin
                    psw_q   <= psw_d;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // alu result is captured on the edge that ends EXEC
    always_ff @(posedge clk) begin
        if (state_q == S_EXEC) begin
            d_q   <= alu_d;
            psr_q <= alu_psr;
        end
    end

    pdp11_regfile #(.REG_RESET(REG_RESET)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra_i  (dec_ir.ra),
        .rb_i  (dec_ir.rb),
        .dbg_i (dbg_sel),
        .we_i  (we),
        .wa_i  (dec_ir.wa),
        .wd_i  (wd_d),
        .ra_o  (rd_a),
        .rb_o  (rd_b),
        .dbg_o (dbg_data)
    );

    assign instr_ready = (state_q == S_IDLE);
    assign done        = done_q;
    assign trap        = trap_q;
    assign alu_op      = ir_q[15:6];
    assign alu_a       = dec_ir.a_zero ? 16'h0 : rd_a;
    assign alu_b       = rd_b;
    assign alu_ps      = psw_q;
    assign psw         = psw_q;

endmodule

// File: tb/tb_pdp11_exec.sv
// Bench for pdp11_exec with a behavioural alu model attached to the alu ports.
module tb_pdp11_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        done;
    logic        trap;
    logic [9:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_ps;
    logic [15:0] alu_d;
    logic [7:0]  alu_psr;
    logic [7:0]  psw;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        trap;
        logic [2:0]  rd;
        logic [15:0] val;
        logic [7:0]  psw;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pdp11_exec #(.RESET_PSW(8'h00), .REG_RESET(16'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .done        (done),
        .trap        (trap),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ps      (alu_ps),
        .alu_d       (alu_d),
        .alu_psr     (alu_psr),
        .psw         (psw),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    // Behavioural alu: returns {psr, d}
    function automatic logic [23:0] alu_model(input logic [9:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic [7:0] ps);
        logic [15:0] r;
        logic [16:0] s;
        logic n, z, v, c, byt;
        int cnt;
        r = b; c = ps[0]; v = ps[1]; byt = 1'b0;
        if (op[9:3] == 7'o072) begin
            cnt = a[5] ? (64 - int'(a[5:0])) : int'(a[5:0]);
            for (int k = 0; k < 32; k++) begin
                if (k < cnt) begin
                    if (a[5]) begin c = r[0];  r = {r[15], r[15:1]}; end
                    else      begin c = r[15]; r = {r[14:0], 1'b0};  end
                end
            end
            v = (r[15] != b[15]);
        end else if (op[9:3] == 7'o074) begin
            r = a ^ b; v = 1'b0;
        end else if (op == 10'o1064) begin
            return {b[7:0], b};
        end else if (op[8:0] == 9'o050) begin
            r = 16'h0; v = 1'b0; c = 1'b0;
        end else if (op == 10'o052) begin
            r = b + 16'd1; v = (b == 16'h7FFF);
        end else if (op == 10'o053) begin
            r = b - 16'd1; v = (b == 16'h8000);
        end else if (op == 10'o063) begin
            r = {b[14:0], 1'b0}; c = b[15]; v = r[15] ^ c;
        end else if (op[9:6] == 4'b0001) begin
            r = a; v = 1'b0;
        end else if (op[9:6] == 4'b1001) begin
            r = {b[15:8], a[7:0]}; v = 1'b0; byt = 1'b1;
        end else if (op[9:6] == 4'b0110) begin
            s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
            v = (a[15] == b[15]) && (r[15] != a[15]);
        end else if (op[9:6] == 4'b0010) begin
            s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16];
            v = (a[15] != b[15]) && (r[15] == b[15]);
        end
        n = byt ? r[7] : r[15];
        z = byt ? (r[7:0] == 8'h0) : (r == 16'h0);
        return {ps[7:4], n, z, v, c, r};
    endfunction

    always_comb {alu_psr, alu_d} = alu_model(alu_op, alu_a, alu_b, alu_ps);

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // Issue one instruction and score its outcome against the queued expectation.
    task automatic exec(input logic [15:0] w, input logic exp_trap, input logic [2:0] rd,
                        input logic [15:0] val, input logic [7:0] pw, input string tag,
                        input bit hold);
        exp_t e;
        int   k;
        bit   seen;
        e.trap = exp_trap; e.rd = rd; e.val = val; e.psw = pw;
        sb.push_back(e);
        @(negedge clk);
        check({tag, "_rdy_in"}, 16'(instr_ready), 16'h1);
        instr = w; instr_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            instr_valid = 1'b0;
            instr = 16'($urandom);
        end
        k = 0; seen = 1'b0;
        while (k < 6 && !seen) begin
            @(negedge clk);
            k++;
            if (done || trap) seen = 1'b1;
        end
        instr_valid = 1'b0;
        e = sb.pop_front();
        check({tag, "_seen"}, 16'(seen), 16'h1);
        check({tag, "_trap"}, 16'(trap), 16'(e.trap));
        check({tag, "_done"}, 16'(done), 16'(!e.trap));
        check({tag, "_lat"}, 16'(k), e.trap ? 16'd1 : 16'd2);
        check({tag, "_busy"}, 16'(instr_ready), 16'h0);
        @(negedge clk);
        dbg_sel = e.rd; #1;
        check({tag, "_rdy_out"}, 16'(instr_ready), 16'h1);
        check({tag, "_pulse"}, 16'(done | trap), 16'h0);
        check({tag, "_reg"}, dbg_data, e.val);
        check({tag, "_psw"}, 16'(psw), 16'(e.psw));
    endtask

    task automatic sweep_reset(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i); #1;
            check($sformatf("%s_r%0d", tag, i), dbg_data, 16'h0);
        end
        check({tag, "_psw"}, 16'(psw), 16'h00);
        check({tag, "_rdy"}, 16'(instr_ready), 16'h1);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; instr_valid = 1'b0; instr = 16'h0; dbg_sel = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done", 16'(done), 16'h0);
        check("rst_trap", 16'(trap), 16'h0);
        check("rst_op", 16'(alu_op), 16'h0);
        reset = 1'b0;
        @(negedge clk);
        sweep_reset("reset");

        // R1=5, R2=3
        for (int i = 1; i <= 5; i++) exec(16'o005201, 1'b0, 3'd1, 16'(i), 8'h00, "inc_r1", 1'b0);
        for (int i = 1; i <= 3; i++) exec(16'o005202, 1'b0, 3'd2, 16'(i), 8'h00, "inc_r2", 1'b0);
        exec(16'o060102, 1'b0, 3'd2, 16'd8, 8'h00, "add", 1'b0);
        exec(16'o020201, 1'b0, 3'd2, 16'd8, 8'h00, "cmp", 1'b0);

        // R3=0x0080, then MOVB sign extension
        exec(16'o005203, 1'b0, 3'd3, 16'h0001, 8'h00, "inc_r3", 1'b0);
        for (int i = 1; i <= 7; i++) exec(16'o006303, 1'b0, 3'd3, 16'(1 << i), 8'h00, "asl_r3", 1'b0);
        exec(16'o110304, 1'b0, 3'd4, 16'hFF80, 8'h08, "movb", 1'b0);

        // Non-register modes
        exec(16'o061102, 1'b1, 3'd2, 16'd8, 8'h08, "trap_src", 1'b0);
        exec(16'o005010, 1'b1, 3'd0, 16'h0, 8'h08, "trap_dst", 1'b0);

        // R5=0x00FF
        exec(16'o005205, 1'b0, 3'd5, 16'h0001, 8'h00, "inc_r5", 1'b0);
        for (int i = 1; i <= 8; i++) exec(16'o006305, 1'b0, 3'd5, 16'(1 << i), 8'h00, "asl_r5", 1'b0);
        exec(16'o005305, 1'b0, 3'd5, 16'h00FF, 8'h00, "dec_r5", 1'b0);

        // R0=FFFF, C set via ASL of R6, INC R0 wraps keeping C
        exec(16'o005300, 1'b0, 3'd0, 16'hFFFF, 8'h08, "dec_r0", 1'b0);
        exec(16'o005306, 1'b0, 3'd6, 16'hFFFF, 8'h08, "dec_r6", 1'b0);
        exec(16'o006306, 1'b0, 3'd6, 16'hFFFE, 8'h09, "asl_r6", 1'b0);
        exec(16'o005200, 1'b0, 3'd0, 16'h0000, 8'h05, "inc_wrap", 1'b0);
        exec(16'o106405, 1'b0, 3'd5, 16'h00FF, 8'hEF, "mtps", 1'b0);

        // EIS operands: R0=-1 (count), R1=1
        exec(16'o005300, 1'b0, 3'd0, 16'hFFFF, 8'hE9, "dec_r0b", 1'b0);
        for (int i = 4; i >= 1; i--) exec(16'o005301, 1'b0, 3'd1, 16'(i), 8'hE1, "dec_r1", 1'b0);
`ifdef PDP11_EIS_EN
        exec(16'o072100, 1'b0, 3'd1, 16'h0000, 8'hE5, "ash", 1'b0);
        exec(16'o074203, 1'b0, 3'd3, 16'h0088, 8'hE1, "xor", 1'b0);
`else
        exec(16'o072100, 1'b1, 3'd1, 16'h0001, 8'hE1, "ash_trap", 1'b0);
        exec(16'o074203, 1'b1, 3'd3, 16'h0080, 8'hE1, "xor_trap", 1'b0);
`endif

        // valid held through EXEC/WB: must execute exactly once
        exec(16'o005204, 1'b0, 3'd4, 16'hFF81, 8'hE9, "hold", 1'b1);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || trap) pulses++;
        end
        check("hold_extra", 16'(pulses), 16'h0);

        // Reset during EXEC aborts the instruction
        @(negedge clk);
        instr = 16'o005302; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(negedge clk);
        check("abort_in_exec", 16'(instr_ready), 16'h0);
        reset = 1'b1; #2; reset = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || trap) pulses++;
        end
        check("abort_pulses", 16'(pulses), 16'h0);
        sweep_reset("abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
